// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and constants for the UART TX round-robin arbiter.
//   arb_state_e : arbiter FSM states (IDLE / HDR / XFER)
//   HDR_TAG     : upper nibble of the optional packet header byte
//   MAX_REQ     : largest supported requester count (header carries 4-bit index)
// The HDR state is used only when UART_ARB_HDR_EN is defined.
// -----------------------------------------------------------------------------
package uart_arb_pkg;

  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned HDR_BITS = 8;
  localparam logic [3:0]  HDR_TAG  = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_e;

  // Header byte announcing which requester owns the following packet.
  function automatic logic [HDR_BITS-1:0] hdr_byte(input logic [3:0] idx);
    return {HDR_TAG, idx};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: finds the first set bit of req searching
// upward from ptr+1, wrapping modulo N_REQ.
//   req      : request vector
//   ptr      : index of the most recent winner
//   pick     : one-hot winner (all zeros when req is empty)
//   pick_idx : binary index of the winner (don't-care when req is empty)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx
);

  // One extra bit so ptr+1+offset (at most 2*N_REQ-1) never overflows.
  localparam int unsigned SW = IW + 1;

  logic [SW-1:0]    start;
  logic [N_REQ-1:0] rot;
  logic [IW-1:0]    off;
  logic             hit;

  // Reduce a value in [0, 2*N_REQ) to a requester index.
  function automatic logic [IW-1:0] wrap(input logic [SW-1:0] v);
    if (v >= SW'(N_REQ)) begin
      return IW'(v - SW'(N_REQ));
    end
    return IW'(v);
  endfunction

  assign start = SW'(ptr) + SW'(1);

  // Rotate so that the requester after ptr lands at bit 0.
  always_comb begin : rotate
    rot = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      rot[j] = req[wrap(start + SW'(j))];
    end
  end

  // Lowest set bit of the rotated vector.
  always_comb begin : prio_enc
    hit = 1'b0;
    off = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!hit && rot[j]) begin
        hit = 1'b1;
        off = IW'(j);
      end
    end
  end

  // Un-rotate back to an absolute requester index.
  assign pick_idx = wrap(start + SW'(off));
  assign pick     = hit ? (N_REQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART TX FIFO write port between N_REQ byte-stream requesters.
// The grant is locked to one requester for a whole packet (terminated by
// req_last) so packets never interleave on the serial line.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   req_valid    : [N_REQ]       requester i has a byte
//   req_data     : [N_REQ*DBIT]  byte of requester i at [i*DBIT +: DBIT]
//   req_last     : [N_REQ]       current byte ends the packet
//   req_ready    : [N_REQ]       byte of requester i accepted this cycle
//   wr_uart      : write strobe to the UART TX FIFO (same-cycle with tx_full)
//   w_data       : [DBIT] byte written to the FIFO (zero when not writing)
//   tx_full      : UART TX FIFO full
//   grant        : [N_REQ] one-hot packet owner, zero when idle
//   busy         : a packet is in progress
//
// Optional feature: define UART_ARB_HDR_EN to emit a header byte
// {HDR_TAG, owner[3:0]} before every packet (requires DBIT >= 8).
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DBIT  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DBIT-1:0] req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  wr_uart,
  output logic [DBIT-1:0]       w_data,
  input  logic                  tx_full,
  output logic [N_REQ-1:0]      grant,
  output logic                  busy
);

  localparam int unsigned IW = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;

  logic             cur_valid;
  logic             cur_last;
  logic [DBIT-1:0]  cur_data;
  logic             xfer;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req      (req_valid),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // ptr_q doubles as the owner index while a packet is in progress.
  assign cur_valid = req_valid[ptr_q];
  assign cur_last  = req_last[ptr_q];
  assign cur_data  = req_data[DBIT*ptr_q +: DBIT];
  assign xfer      = (state_q == ST_XFER) && cur_valid && !tx_full;

  // State, round-robin pointer and grant registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          ptr_d   = pick_idx;
          grant_d = pick;
`ifdef UART_ARB_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_XFER;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      ST_HDR: begin
        if (!tx_full) begin
          state_d = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        if (xfer && cur_last) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output logic: FIFO write side is combinational so tx_full is honoured
  // in the same cycle.
  always_comb begin
    req_ready = '0;
    wr_uart   = 1'b0;
    w_data    = '0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
`ifdef UART_ARB_HDR_EN
      ST_HDR: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = DBIT'(hdr_byte(4'(ptr_q)));
        end
      end
`endif
      ST_XFER: begin
        req_ready[ptr_q] = !tx_full;
        wr_uart          = xfer;
        if (xfer) begin
          w_data = cur_data;
        end
      end
      default: begin
        req_ready = '0;
      end
    endcase
  end

  assign grant = grant_q;

endmodule
